memory_vectorreader: RTL and testbench
======================================

// Module: memory_vectorreader
// PURPOSE
//  Read side of the vector memory. On a start pulse, walks addresses 0..length-1 of the
//  synchronous vector RAM (1-cycle read latency) and presents each word to the vector
//  drawer over a valid/ready handshake. Pulses done after the last word is accepted.
//  Sits between the vector RAM read port and the line-drawing engine.
// PARAMETERS
//  ADDRESSWIDTH  10  width of RAM address and of the length input
//  DATAWIDTH     32  width of one stored vector word
// PORTS
//  clk        in   1             system clock, all logic on posedge
//  rst_n      in   1             asynchronous active-low reset
//  start      in   1             pulse: latch length, begin read pass (ignored while busy)
//  abort      in   1             return to IDLE next cycle, no done pulse
//  length     in   ADDRESSWIDTH  number of stored vectors, sampled on accepted start
//  rd_en      out  1             RAM read enable
//  rd_adr     out  ADDRESSWIDTH  RAM read address
//  rd_data    in   DATAWIDTH     RAM data, valid the cycle after rd_en
//  vec_data   out  DATAWIDTH     vector word to drawer
//  vec_valid  out  1             vec_data valid
//  vec_ready  in   1             drawer accepts when vec_valid & vec_ready
//  busy       out  1             high in any state except IDLE
//  done       out  1             one-cycle pulse after last vector accepted
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE; rd_en, vec_valid, busy, done = 0; rd_adr,
//    vec_data, latched length = 0.
//  - States: IDLE -> READ -> LATCH -> PRESENT -> (READ | IDLE).
//    IDLE: start=1 & length!=0 -> latch length, adr=0, go READ. start=1 & length==0 ->
//      done pulse next cycle, stay IDLE, no RAM access.
//    READ: rd_en=1 for exactly one cycle at rd_adr; go LATCH.
//    LATCH: capture rd_data into vec_data register; go PRESENT.
//    PRESENT: vec_valid=1, vec_data stable until accept. On accept: if adr==len-1 ->
//      done=1 next cycle, IDLE; else adr+1, READ.
//  - Throughput: one vector per 3 cycles with vec_ready held high; rd_en to vec_valid = 2.
//  - vec_valid never drops without accept except on abort/reset.
//  - abort has priority over all transitions in every state; beats start in IDLE.
//  - start while busy ignored; length changes after start do not affect the pass.
//  - Address arithmetic modulo 2^ADDRESSWIDTH; max pass length 2^ADDRESSWIDTH-1.
//  - done and vec_valid never high in the same cycle.
// CONFIGURATION
//  MEMORY_VECTORREADER_LOOP_EN defined: after last accept, done pulses and FSM returns
//   to READ at adr=0 with the same latched length (continuous display refresh); only
//   abort or reset reaches IDLE; busy stays 1. length==0 start behaves as without macro.
//  Not defined: single pass, IDLE after last vector as above.
// STRUCTURE
//  - memory_pkg: vr_state_t enum (IDLE, READ, LATCH, PRESENT), default ADDRESSWIDTH /
//    DATAWIDTH localparams shared with the vector-memory write side.
//  - Sub-module vector_adr_counter: address register with zero/inc controls, async
//    active-low reset; FSM drives zero on start, inc on non-final accept.
// TESTING
//  - Reset mid-PRESENT: rst_n=0 -> vec_valid, busy, rd_en = 0 immediately; rd_adr=0.
//  - length=4, vec_ready=1, RAM[i]=0xA000+i -> words A000..A003 in order, rd_adr 0..3,
//    done pulse once, 12 cycles start->done, busy low after.
//  - length=3, vec_ready stalled 5 cycles on word 1 -> vec_data held 0xA001, no extra
//    rd_en, sequence unchanged.
//  - length=0 start -> done next cycle, rd_en never asserted, busy stays 0.
//  - abort during LATCH of word 2 -> IDLE next cycle, no done; new start length=2 reads
//    from adr 0.
//  - LOOP_EN, length=2 -> A000,A001,done,A000,A001,done...; abort ends loop, busy=0.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared vector-memory definitions: reader FSM states and default widths,
// used by both the read side and the write side of the vector memory.
package memory_pkg;

    localparam int MEM_ADDRESSWIDTH = 10;
    localparam int MEM_DATAWIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        LATCH   = 2'd2,
        PRESENT = 2'd3
    } vr_state_t;

endpackage

// File: rtl/vector_adr_counter.sv
// Vector RAM read-address register: synchronous clear and increment,
// asynchronous active-low reset. Wraps modulo 2^W.
module vector_adr_counter #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         zero,
    input  logic         inc,
    output logic [W-1:0] adr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr <= '0;
        end else if (zero) begin
            adr <= '0;
        end else if (inc) begin
            adr <= adr + W'(1);
        end
    end

endmodule

// File: rtl/memory_vectorreader.sv
// Vector RAM read side: walks addresses 0..length-1 and hands each word to the drawer.
// Define MEMORY_VECTORREADER_LOOP_EN to repeat the pass continuously until abort.
module memory_vectorreader
    import memory_pkg::*;
#(
    parameter int ADDRESSWIDTH = MEM_ADDRESSWIDTH,
    parameter int DATAWIDTH    = MEM_DATAWIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDRESSWIDTH-1:0] length,
    output logic                    rd_en,
    output logic [ADDRESSWIDTH-1:0] rd_adr,
    input  logic [DATAWIDTH-1:0]    rd_data,
    output logic [DATAWIDTH-1:0]    vec_data,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic                    busy,
    output logic                    done
);

    // Handshake: a word transfers on any cycle with vec_valid & vec_ready; once raised,
    // vec_valid and vec_data hold until that transfer, unless abort or reset intervene.

    vr_state_t               state_q, state_d;
    logic [ADDRESSWIDTH-1:0] len_q;
    logic [DATAWIDTH-1:0]    vec_data_q;
    logic                    done_q, done_d;
    logic                    len_load, vec_load, adr_zero, adr_inc;
    logic                    last;

    assign last = (rd_adr == (len_q - ADDRESSWIDTH'(1)));

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        len_load = 1'b0;
        vec_load = 1'b0;
        adr_zero = 1'b0;
        adr_inc  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (length != '0) begin
                            len_load = 1'b1;
                            adr_zero = 1'b1;
                            state_d  = READ;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                READ:  state_d = LATCH;
                LATCH: begin
                    vec_load = 1'b1;
                    state_d  = PRESENT;
                end
                PRESENT: begin
                    if (vec_ready) begin
                        if (last) begin
                            done_d = 1'b1;
`ifdef MEMORY_VECTORREADER_LOOP_EN
                            adr_zero = 1'b1;
                            state_d  = READ;
`else
                            state_d  = IDLE;
`endif
                        end else begin
                            adr_inc = 1'b1;
                            state_d = READ;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            vec_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (len_load) len_q <= length;
            if (vec_load) vec_data_q <= rd_data;
        end
    end

    vector_adr_counter #(.W(ADDRESSWIDTH)) u_adr (
        .clk  (clk),
        .rst_n(rst_n),
        .zero (adr_zero),
        .inc  (adr_inc),
        .adr  (rd_adr)
    );

    // Outputs decode directly from the state register so reset clears them immediately.
    assign rd_en     = (state_q == READ);
    assign vec_valid = (state_q == PRESENT);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign vec_data  = vec_data_q;

endmodule

// File: tb/tb_memory_vectorreader.sv
// Directed bench for memory_vectorreader with a 1-cycle-latency RAM model holding 0xA000+i.
module tb_memory_vectorreader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  length = '0;
    logic        rd_en;
    logic [9:0]  rd_adr;
    logic [31:0] rd_data = '0;
    logic [31:0] vec_data;
    logic        vec_valid;
    logic        vec_ready = 1'b1;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:1023];
    int          rd_count = 0;
    int          checks = 0;
    int          failures = 0;

    memory_vectorreader #(.ADDRESSWIDTH(10), .DATAWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .length(length),
        .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data), .vec_data(vec_data),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000 + 32'(i);
    end

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data  <= mem[rd_adr];
            rd_count <= rd_count + 1;
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
        checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL reset_vec_valid got=%b exp=0", vec_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (rd_adr !== 10'd0) begin failures++; $display("FAIL reset_rd_adr got=%0d exp=0", rd_adr); end
        checks++; if (vec_data !== 32'd0) begin failures++; $display("FAIL reset_vec_data got=%h exp=0", vec_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single_pass;
        logic [15:0] rd_m, vv_m, bz_m, dn_m;
        int rc0;
        rd_m = 16'h0249; vv_m = 16'h0924; bz_m = 16'h0FFF; dn_m = 16'h1000;
        vec_ready = 1'b1; length = 10'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rc0 = rd_count;
        for (int t = 0; t < 14; t++) begin
            checks++; if (rd_en !== rd_m[t]) begin failures++; $display("FAIL pass_rd_en t=%0d got=%b exp=%b", t, rd_en, rd_m[t]); end
            checks++; if (vec_valid !== vv_m[t]) begin failures++; $display("FAIL pass_valid t=%0d got=%b exp=%b", t, vec_valid, vv_m[t]); end
            checks++; if (busy !== bz_m[t]) begin failures++; $display("FAIL pass_busy t=%0d got=%b exp=%b", t, busy, bz_m[t]); end
            checks++; if (done !== dn_m[t]) begin failures++; $display("FAIL pass_done t=%0d got=%b exp=%b", t, done, dn_m[t]); end
            if (rd_m[t]) begin
                checks++; if (rd_adr !== 10'(t / 3)) begin failures++; $display("FAIL pass_rd_adr t=%0d got=%0d exp=%0d", t, rd_adr, t / 3); end
            end
            if (vv_m[t]) begin
                checks++; if (vec_data !== 32'hA000 + 32'(t / 3)) begin failures++; $display("FAIL pass_data t=%0d got=%h exp=%h", t, vec_data, 32'hA000 + 32'(t / 3)); end
            end
            @(posedge clk); #1;
        end
        checks++; if (rd_count - rc0 !== 4) begin failures++; $display("FAIL pass_rd_count got=%0d exp=4", rd_count - rc0); end
    endtask

    task automatic test_stall;
        logic [15:0] rd_m, vv_m, bz_m, dn_m;
        logic [31:0] exp_d;
        int rc0;
        rd_m = 16'h0809; vv_m = 16'h27E4; bz_m = 16'h3FFF; dn_m = 16'h4000;
        length = 10'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rc0 = rd_count;
        for (int t = 0; t < 16; t++) begin
            vec_ready = !(t >= 5 && t <= 9);
            exp_d = (t < 5) ? 32'hA000 : (t < 11) ? 32'hA001 : 32'hA002;
            checks++; if (rd_en !== rd_m[t]) begin failures++; $display("FAIL stall_rd_en t=%0d got=%b exp=%b", t, rd_en, rd_m[t]); end
            checks++; if (vec_valid !== vv_m[t]) begin failures++; $display("FAIL stall_valid t=%0d got=%b exp=%b", t, vec_valid, vv_m[t]); end
            checks++; if (busy !== bz_m[t]) begin failures++; $display("FAIL stall_busy t=%0d got=%b exp=%b", t, busy, bz_m[t]); end
            checks++; if (done !== dn_m[t]) begin failures++; $display("FAIL stall_done t=%0d got=%b exp=%b", t, done, dn_m[t]); end
            if (vv_m[t]) begin
                checks++; if (vec_data !== exp_d) begin failures++; $display("FAIL stall_data t=%0d got=%h exp=%h", t, vec_data, exp_d); end
            end
            @(posedge clk); #1;
        end
        vec_ready = 1'b1;
        checks++; if (rd_count - rc0 !== 3) begin failures++; $display("FAIL stall_rd_count got=%0d exp=3", rd_count - rc0); end
    endtask

    task automatic test_zero_length;
        int rc0;
        rc0 = rd_count;
        length = 10'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b exp=0", busy); end
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL zero_rd_en got=%b exp=0", rd_en); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (rd_count !== rc0) begin failures++; $display("FAIL zero_rd_count got=%0d exp=%0d", rd_count - rc0, 0); end
    endtask

    task automatic test_abort;
        logic [7:0] rd_m, vv_m, bz_m, dn_m;
        rd_m = 8'h09; vv_m = 8'h24; bz_m = 8'h3F; dn_m = 8'h40;
        length = 10'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++; if (vec_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL abort_latch_state got_valid=%b got_busy=%b exp=0/1", vec_valid, busy); end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", vec_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", done); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done_late got=%b exp=0", done); end
        length = 10'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 8; t++) begin
            checks++; if (rd_en !== rd_m[t]) begin failures++; $display("FAIL restart_rd_en t=%0d got=%b exp=%b", t, rd_en, rd_m[t]); end
            checks++; if (vec_valid !== vv_m[t]) begin failures++; $display("FAIL restart_valid t=%0d got=%b exp=%b", t, vec_valid, vv_m[t]); end
            checks++; if (busy !== bz_m[t]) begin failures++; $display("FAIL restart_busy t=%0d got=%b exp=%b", t, busy, bz_m[t]); end
            checks++; if (done !== dn_m[t]) begin failures++; $display("FAIL restart_done t=%0d got=%b exp=%b", t, done, dn_m[t]); end
            if (rd_m[t]) begin
                checks++; if (rd_adr !== 10'(t / 3)) begin failures++; $display("FAIL restart_rd_adr t=%0d got=%0d exp=%0d", t, rd_adr, t / 3); end
            end
            if (vv_m[t]) begin
                checks++; if (vec_data !== 32'hA000 + 32'(t / 3)) begin failures++; $display("FAIL restart_data t=%0d got=%h exp=%h", t, vec_data, 32'hA000 + 32'(t / 3)); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort_beats_start;
        length = 10'd3; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_start_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_start_done got=%b exp=0", done); end
        @(posedge clk); #1;
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL abort_start_rd_en got=%b exp=0", rd_en); end
    endtask

    task automatic test_ignore_while_busy;
        length = 10'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 8; t++) begin
            if (t == 1) length = 10'd5;
            start = (t == 3);
            if (t == 5) begin
                checks++; if (vec_data !== 32'hA001 || vec_valid !== 1'b1) begin failures++; $display("FAIL busy_data got=%h/%b exp=%h/1", vec_data, vec_valid, 32'hA001); end
            end
            if (t == 6) begin
                checks++; if (done !== 1'b1) begin failures++; $display("FAIL busy_done got=%b exp=1", done); end
            end
            if (t >= 6) begin
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_idle t=%0d got=%b exp=0", t, busy); end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_present;
        length = 10'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (vec_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b exp=1", vec_valid); end
        vec_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", vec_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL rstmid_rd_en got=%b exp=0", rd_en); end
        checks++; if (rd_adr !== 10'd0) begin failures++; $display("FAIL rstmid_rd_adr got=%0d exp=0", rd_adr); end
        @(negedge clk);
        rst_n = 1'b1;
        vec_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_after_busy got=%b exp=0", busy); end
    endtask

`ifdef MEMORY_VECTORREADER_LOOP_EN
    task automatic test_loop;
        logic [15:0] rd_m, vv_m, dn_m;
        rd_m = 16'h9249; vv_m = 16'h4924; dn_m = 16'h1040;
        length = 10'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 16; t++) begin
            checks++; if (rd_en !== rd_m[t]) begin failures++; $display("FAIL loop_rd_en t=%0d got=%b exp=%b", t, rd_en, rd_m[t]); end
            checks++; if (vec_valid !== vv_m[t]) begin failures++; $display("FAIL loop_valid t=%0d got=%b exp=%b", t, vec_valid, vv_m[t]); end
            checks++; if (done !== dn_m[t]) begin failures++; $display("FAIL loop_done t=%0d got=%b exp=%b", t, done, dn_m[t]); end
            checks++; if (busy !== 1'b1) begin failures++; $display("FAIL loop_busy t=%0d got=%b exp=1", t, busy); end
            if (rd_m[t]) begin
                checks++; if (rd_adr !== 10'((t / 3) % 2)) begin failures++; $display("FAIL loop_rd_adr t=%0d got=%0d exp=%0d", t, rd_adr, (t / 3) % 2); end
            end
            if (vv_m[t]) begin
                checks++; if (vec_data !== 32'hA000 + 32'((t / 3) % 2)) begin failures++; $display("FAIL loop_data t=%0d got=%h exp=%h", t, vec_data, 32'hA000 + 32'((t / 3) % 2)); end
            end
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL loop_abort_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL loop_abort_done got=%b exp=0", done); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef MEMORY_VECTORREADER_LOOP_EN
        test_zero_length();
        test_abort_beats_start();
        test_loop();
        test_reset_mid_present();
`else
        test_single_pass();
        test_stall();
        test_zero_length();
        test_abort();
        test_abort_beats_start();
        test_ignore_while_busy();
        test_reset_mid_present();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
